// File: rtl/arb_out_buffer.sv
`default_nettype none
// ============================================================================
// Module   : arb_out_buffer
// Purpose  : Elastic FIFO stage between the data arbiter and the readout FIFO,
//            with near-full throttling and word/overflow counters.
//            Optional end-of-run trailer word: define ARB_OUT_TRAILER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module arb_out_buffer #(
  parameter int DEPTH_LOG2   = 4,
  parameter int THROTTLE_DIV = 4
) (
  input  logic        BUS_CLK,
  input  logic        BUS_RST,
  input  logic        ENABLE,
  input  logic        ARB_WRITE_OUT,
  input  logic [31:0] ARB_DATA_OUT,
  output logic        ARB_READY_OUT,
  input  logic        FIFO_FULL,
  input  logic        FIFO_NEAR_FULL,
  output logic        FIFO_WRITE,
  output logic [31:0] FIFO_DATA,
  output logic [31:0] WORD_COUNT,
  output logic [15:0] OVF_COUNT,
  output logic        BUSY
);

  localparam int PTR_W = DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0] DEPTH_WORDS = CNT_W'(1 << DEPTH_LOG2);
  localparam logic [3:0]       DIV_LAST    = 4'(THROTTLE_DIV - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STREAM   = 2'd1,
`ifdef ARB_OUT_TRAILER_EN
    THROTTLE = 2'd2,
    TRAILER  = 2'd3
`else
    THROTTLE = 2'd2
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       mem_q [0:(1<<DEPTH_LOG2)-1];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [3:0]        div_q, div_d;
  logic              fifo_write_q, fifo_write_d;
  logic [31:0]       fifo_data_q, fifo_data_d;
  logic [31:0]       word_count_q, word_count_d;
  logic [15:0]       ovf_count_q, ovf_count_d;

  logic empty, full, ready, accept, drain_data, trailer_emit, trailer_pending;

  assign empty         = (count_q == '0);
  assign full          = (count_q == DEPTH_WORDS);
  assign ready         = ENABLE & ~full;
  assign accept        = ARB_WRITE_OUT & ready;
  assign drain_data    = ~empty & ~FIFO_FULL &
                         ((state_q == STREAM) | ((state_q == THROTTLE) & (div_q == DIV_LAST)));
  assign ARB_READY_OUT = ready;

`ifdef ARB_OUT_TRAILER_EN
  logic enable_q, enable_d;
  logic trailer_pending_q, trailer_pending_d;

  assign trailer_emit    = (state_q == TRAILER) & ~FIFO_FULL;
  assign trailer_pending = trailer_pending_q;

  // A later rising edge of ENABLE never clears a pending trailer.
  always_comb begin
    enable_d          = ENABLE;
    trailer_pending_d = (enable_q & ~ENABLE) | (trailer_pending_q & ~trailer_emit);
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      enable_q          <= 1'b0;
      trailer_pending_q <= 1'b0;
    end else begin
      enable_q          <= enable_d;
      trailer_pending_q <= trailer_pending_d;
    end
  end
`else
  assign trailer_emit    = 1'b0;
  assign trailer_pending = 1'b0;
`endif

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    div_d        = div_q;
    state_d      = state_q;
    fifo_write_d = drain_data | trailer_emit;
    fifo_data_d  = fifo_data_q;
    word_count_d = word_count_q;
    ovf_count_d  = ovf_count_q;

    if (accept) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (drain_data) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (accept & ~drain_data) count_d = count_q + CNT_W'(1);
    else if (~accept & drain_data) count_d = count_q - CNT_W'(1);

    if (drain_data) begin
      fifo_data_d  = mem_q[rd_ptr_q];
      word_count_d = word_count_q + 32'd1;
    end else if (trailer_emit) begin
      fifo_data_d  = {4'hF, word_count_q[27:0]};
    end

    if (ARB_WRITE_OUT & ~ready & (ovf_count_q != 16'hFFFF))
      ovf_count_d = ovf_count_q + 16'd1;

    // Transitions look at next-cycle occupancy so a fresh word drains at once.
    case (state_q)
      IDLE: begin
        if (count_d != '0) state_d = STREAM;
`ifdef ARB_OUT_TRAILER_EN
        else if (trailer_pending_q) state_d = TRAILER;
`endif
      end
      STREAM: begin
        if (count_d == '0) state_d = IDLE;
        else if (FIFO_NEAR_FULL) begin
          state_d = THROTTLE;
          div_d   = 4'd0;
        end
      end
      THROTTLE: begin
        if (drain_data) div_d = 4'd0;
        else if (div_q != DIV_LAST) div_d = div_q + 4'd1;
        if (count_d == '0) state_d = IDLE;
        else if (~FIFO_NEAR_FULL) state_d = STREAM;
      end
`ifdef ARB_OUT_TRAILER_EN
      TRAILER: begin
        if (trailer_emit) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge BUS_CLK) begin
    if (accept) mem_q[wr_ptr_q] <= ARB_DATA_OUT;
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      div_q        <= 4'd0;
      fifo_write_q <= 1'b0;
      fifo_data_q  <= 32'd0;
      word_count_q <= 32'd0;
      ovf_count_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      div_q        <= div_d;
      fifo_write_q <= fifo_write_d;
      fifo_data_q  <= fifo_data_d;
      word_count_q <= word_count_d;
      ovf_count_q  <= ovf_count_d;
    end
  end

  assign FIFO_WRITE = fifo_write_q;
  assign FIFO_DATA  = fifo_data_q;
  assign WORD_COUNT = word_count_q;
  assign OVF_COUNT  = ovf_count_q;
  assign BUSY       = ~empty | fifo_write_q | trailer_pending;

endmodule
`default_nettype wire

// File: tb/tb_arb_out_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_arb_out_buffer
// Purpose  : Directed self-checking bench for arb_out_buffer (DEPTH_LOG2=4,
//            THROTTLE_DIV=4); trailer expectations follow ARB_OUT_TRAILER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arb_out_buffer;

  logic        BUS_CLK = 1'b0;
  logic        BUS_RST;
  logic        ENABLE;
  logic        ARB_WRITE_OUT;
  logic [31:0] ARB_DATA_OUT;
  logic        ARB_READY_OUT;
  logic        FIFO_FULL;
  logic        FIFO_NEAR_FULL;
  logic        FIFO_WRITE;
  logic [31:0] FIFO_DATA;
  logic [31:0] WORD_COUNT;
  logic [15:0] OVF_COUNT;
  logic        BUSY;

  int errors = 0;
  int checks = 0;

  arb_out_buffer #(.DEPTH_LOG2(4), .THROTTLE_DIV(4)) dut (
    .BUS_CLK       (BUS_CLK),
    .BUS_RST       (BUS_RST),
    .ENABLE        (ENABLE),
    .ARB_WRITE_OUT (ARB_WRITE_OUT),
    .ARB_DATA_OUT  (ARB_DATA_OUT),
    .ARB_READY_OUT (ARB_READY_OUT),
    .FIFO_FULL     (FIFO_FULL),
    .FIFO_NEAR_FULL(FIFO_NEAR_FULL),
    .FIFO_WRITE    (FIFO_WRITE),
    .FIFO_DATA     (FIFO_DATA),
    .WORD_COUNT    (WORD_COUNT),
    .OVF_COUNT     (OVF_COUNT),
    .BUSY          (BUSY)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge BUS_CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] out_data [0:7];
    int          n_out;
    int          exp_idx;
    logic        exp_wr;

    BUS_RST = 1'b1; ENABLE = 1'b1; ARB_WRITE_OUT = 1'b0; ARB_DATA_OUT = 32'd0;
    FIFO_FULL = 1'b0; FIFO_NEAR_FULL = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_ready", {31'd0, ARB_READY_OUT}, 32'd1);
    chk("rst_wr",    {31'd0, FIFO_WRITE}, 32'd0);
    chk("rst_data",  FIFO_DATA, 32'd0);
    chk("rst_wc",    WORD_COUNT, 32'd0);
    chk("rst_ovf",   {16'd0, OVF_COUNT}, 32'd0);
    chk("rst_busy",  {31'd0, BUSY}, 32'd0);
    BUS_RST = 1'b0;
    tick();

    // Single word: accepted in cycle 0, strobed in cycle 2
    ARB_WRITE_OUT = 1'b1; ARB_DATA_OUT = 32'h1234_5678;
    tick();
    ARB_WRITE_OUT = 1'b0;
    chk("t1_c1_wr",   {31'd0, FIFO_WRITE}, 32'd0);
    chk("t1_c1_busy", {31'd0, BUSY}, 32'd1);
    tick();
    chk("t1_c2_wr",   {31'd0, FIFO_WRITE}, 32'd1);
    chk("t1_c2_data", FIFO_DATA, 32'h1234_5678);
    chk("t1_c2_wc",   WORD_COUNT, 32'd1);
    tick();
    chk("t1_c3_wr",   {31'd0, FIFO_WRITE}, 32'd0);
    chk("t1_c3_busy", {31'd0, BUSY}, 32'd0);

    // Fill to depth with the external FIFO full; 17th offer overflows
    FIFO_FULL = 1'b1;
    for (int i = 0; i < 17; i++) begin
      ARB_WRITE_OUT = 1'b1; ARB_DATA_OUT = 32'hA000_0000 + i;
      if (i == 15) chk("t2_ready_before_full", {31'd0, ARB_READY_OUT}, 32'd1);
      if (i == 16) chk("t2_ready_at_full", {31'd0, ARB_READY_OUT}, 32'd0);
      tick();
    end
    ARB_WRITE_OUT = 1'b0;
    chk("t2_ovf",  {16'd0, OVF_COUNT}, 32'd1);
    chk("t2_busy", {31'd0, BUSY}, 32'd1);
    chk("t2_hold", {31'd0, FIFO_WRITE}, 32'd0);
    FIFO_FULL = 1'b0;
    for (int j = 0; j < 16; j++) begin
      tick();
      chk("t2_drain_wr", {31'd0, FIFO_WRITE}, 32'd1);
      chk("t2_drain_data", FIFO_DATA, 32'hA000_0000 + j);
      if (j == 0) chk("t2_ready_after_drain", {31'd0, ARB_READY_OUT}, 32'd1);
    end
    tick();
    chk("t2_end_wr", {31'd0, FIFO_WRITE}, 32'd0);
    chk("t2_wc",     WORD_COUNT, 32'd17);

    // Throttle: 8 buffered words, near-full -> one strobe every 4 cycles
    FIFO_FULL = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ARB_WRITE_OUT = 1'b1; ARB_DATA_OUT = 32'hB000_0000 + i;
      tick();
    end
    ARB_WRITE_OUT = 1'b0;
    FIFO_FULL = 1'b0; FIFO_NEAR_FULL = 1'b1;
    exp_idx = 0;
    for (int t = 1; t <= 17; t++) begin
      tick();
      exp_wr = (t <= 13) ? ((t % 4) == 1) : 1'b1;
      chk("t3_wr_pattern", {31'd0, FIFO_WRITE}, {31'd0, exp_wr});
      if (FIFO_WRITE) begin
        chk("t3_data", FIFO_DATA, 32'hB000_0000 + exp_idx);
        exp_idx++;
      end
      if (t == 12) FIFO_NEAR_FULL = 1'b0;
    end
    tick();
    chk("t3_end_wr", {31'd0, FIFO_WRITE}, 32'd0);
    chk("t3_count",  exp_idx, 32'd8);

    // Pass-through at occupancy 0: back-to-back words, 2-cycle latency
    for (int t = 0; t < 6; t++) begin
      ARB_WRITE_OUT = (t < 3);
      ARB_DATA_OUT  = 32'hC000_0000 + t;
      chk("t4_wr", {31'd0, FIFO_WRITE}, {31'd0, (t >= 2 && t <= 4)});
      if (t >= 2 && t <= 4) chk("t4_data", FIFO_DATA, 32'hC000_0000 + t - 2);
      tick();
    end
    ARB_WRITE_OUT = 1'b0;

    // Reset with 5 words buffered discards everything
    FIFO_FULL = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ARB_WRITE_OUT = 1'b1; ARB_DATA_OUT = 32'hD000_0000 + i;
      tick();
    end
    ARB_WRITE_OUT = 1'b0;
    BUS_RST = 1'b1;
    tick();
    BUS_RST = 1'b0;
    chk("t5_wr",    {31'd0, FIFO_WRITE}, 32'd0);
    chk("t5_busy",  {31'd0, BUSY}, 32'd0);
    chk("t5_wc",    WORD_COUNT, 32'd0);
    chk("t5_ovf",   {16'd0, OVF_COUNT}, 32'd0);
    chk("t5_ready", {31'd0, ARB_READY_OUT}, 32'd1);
    FIFO_FULL = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk("t5_no_stale", {31'd0, FIFO_WRITE}, 32'd0);
    end

    // Three words then ENABLE falls: trailer appears only with the macro
    n_out = 0;
    for (int t = 0; t < 15; t++) begin
      ARB_WRITE_OUT = (t < 3);
      ENABLE        = (t < 3);
      ARB_DATA_OUT  = 32'hE000_0000 + t;
      if (FIFO_WRITE) begin
        if (n_out < 8) out_data[n_out] = FIFO_DATA;
        n_out++;
      end
      tick();
    end
    ENABLE = 1'b1;
`ifdef ARB_OUT_TRAILER_EN
    chk("t6_n_out", n_out, 32'd4);
    if (n_out >= 4) chk("t6_trailer", out_data[3], 32'hF000_0003);
`else
    chk("t6_n_out", n_out, 32'd3);
`endif
    for (int k = 0; k < 3; k++)
      if (k < n_out) chk("t6_data", out_data[k], 32'hE000_0000 + k);
    chk("t6_wc",   WORD_COUNT, 32'd3);
    chk("t6_busy", {31'd0, BUSY}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
